// File: rtl/npc_inst_pkg.sv
// Shared encoding constants and the FIFO entry type for the RV32I subset encoder.
package npc_inst_pkg;

  typedef enum logic [2:0] {
    OP_AUIPC  = 3'd0,
    OP_JAL    = 3'd1,
    OP_JALR   = 3'd2,
    OP_SW     = 3'd3,
    OP_ADDI   = 3'd4,
    OP_EBREAK = 3'd5,
    OP_ILL6   = 3'd6,
    OP_ILL7   = 3'd7
  } op_e;

  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ZERO = 3'b000;
  localparam logic [2:0] F3_SW   = 3'b010;

  // {funct3, opcode[6:2]} as seen by the decode LUT
  localparam logic [7:0] PAT_AUIPC  = 8'h05;
  localparam logic [7:0] PAT_JAL    = 8'h1B;
  localparam logic [7:0] PAT_JALR   = 8'h19;
  localparam logic [7:0] PAT_SW     = 8'h48;
  localparam logic [7:0] PAT_ADDI   = 8'h04;
  localparam logic [7:0] PAT_EBREAK = 8'h1C;

  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  typedef struct packed {
    logic [31:0] inst;
    logic [7:0]  pattern;
    logic        err;
  } enc_entry_t;

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bundle of the instruction encoder; master drives requests, slave is the encoder.
interface inst_encoder_if #(
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [7:0]       out_pattern;
  logic             out_err;
  logic             err_sticky;
  logic [CNT_W-1:0] enc_count;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_pattern, out_err, err_sticky, enc_count
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_pattern, out_err, err_sticky, enc_count
  );
endinterface

// File: rtl/inst_enc_fifo.sv
// Synchronous FIFO of encoded entries; the head output holds the last popped entry while empty.
module inst_enc_fifo
  import npc_inst_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  enc_entry_t entry_i,
  input  logic       pop_i,
  output enc_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(DEPTH + 1);

  enc_entry_t        mem_q [DEPTH];
  enc_entry_t        last_q, last_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (fill_q == FILL_W'(DEPTH));
  assign empty_o = (fill_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    last_d   = last_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
      last_d   = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      last_q   <= last_d;
    end
  end

  // Storage is data only; occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/inst_encoder.sv
// Encodes {op, rd, rs1, rs2, imm} requests into RV32I words and queues them for the consumer.
module inst_encoder
  import npc_inst_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  inst_encoder_if.slave  bus
);
  enc_entry_t         enc_d;
  enc_entry_t         head;
  logic signed [31:0] imm_s;
  logic               fifo_full, fifo_empty;
  logic               accept;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sticky_q, sticky_d;

  function automatic logic fits_s12(logic signed [31:0] v);
    return (v >= -32'sd2048) && (v <= 32'sd2047);
  endfunction

  function automatic logic fits_jal(logic signed [31:0] v);
    return (v >= -32'sd1048576) && (v <= 32'sd1048574) && !v[0];
  endfunction

  assign imm_s  = bus.in_imm;
  assign accept = bus.in_valid && !fifo_full;

  always_comb begin
    enc_d = '{inst: NOP_INST, pattern: PAT_ADDI, err: 1'b1};
    case (op_e'(bus.in_op))
      OP_AUIPC:
        enc_d = '{inst: {imm_s[31:12], bus.in_rd, OPC_AUIPC},
                  pattern: PAT_AUIPC, err: (imm_s[11:0] != 12'd0)};
      OP_JAL:
        enc_d = '{inst: {imm_s[20], imm_s[10:1], imm_s[11], imm_s[19:12], bus.in_rd, OPC_JAL},
                  pattern: PAT_JAL, err: !fits_jal(imm_s)};
      OP_JALR:
        enc_d = '{inst: {imm_s[11:0], bus.in_rs1, F3_ZERO, bus.in_rd, OPC_JALR},
                  pattern: PAT_JALR, err: !fits_s12(imm_s)};
      OP_SW:
        enc_d = '{inst: {imm_s[11:5], bus.in_rs2, bus.in_rs1, F3_SW, imm_s[4:0], OPC_STORE},
                  pattern: PAT_SW, err: !fits_s12(imm_s)};
      OP_ADDI:
        enc_d = '{inst: {imm_s[11:0], bus.in_rs1, F3_ZERO, bus.in_rd, OPC_OP_IMM},
                  pattern: PAT_ADDI, err: !fits_s12(imm_s)};
      OP_EBREAK:
        enc_d = '{inst: EBREAK_INST, pattern: PAT_EBREAK, err: 1'b0};
      default: ;
    endcase
    // Any rejected request is replaced by a NOP so the stream stays executable.
    if (enc_d.err) enc_d = '{inst: NOP_INST, pattern: PAT_ADDI, err: 1'b1};
  end

  always_comb begin
    count_d  = count_q;
    sticky_d = sticky_q;
    if (accept) begin
      count_d  = count_q + CNT_W'(1);
      sticky_d = sticky_q | enc_d.err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  inst_enc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.in_valid),
    .entry_i (enc_d),
    .pop_i   (bus.out_ready),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.in_ready    = !fifo_full;
  assign bus.out_valid   = !fifo_empty;
  assign bus.out_inst    = head.inst;
  assign bus.out_pattern = head.pattern;
  assign bus.out_err     = head.err;
  assign bus.err_sticky  = sticky_q;
  assign bus.enc_count   = count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: randomized and directed requests against an arithmetic reference model.
module tb_inst_encoder;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_encoder_if #(.CNT_W(32)) bus ();

  inst_encoder #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] inst;
    logic [7:0]  pat;
    logic        err;
    bit          has_lit;
    logic [31:0] lit_inst;
    logic [7:0]  lit_pat;
    logic        lit_err;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned model_cnt = 0;
  bit          model_sticky = 1'b0;
  bit          mon_en = 1'b0;
  bit          rand_rdy = 1'b0;
  bit          lit_has = 1'b0;
  logic [31:0] lit_inst = '0;
  logic [7:0]  lit_pat = '0;
  logic        lit_err = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: field placement computed with shifts and masks from the instruction formats.
  function automatic exp_t model(logic [2:0] op, logic [4:0] rd, logic [4:0] rs1,
                                 logic [4:0] rs2, logic [31:0] imm);
    exp_t e;
    int   simm;
    logic [31:0] r_d, r_s1, r_s2;
    simm = imm;
    r_d  = 32'(rd) << 7;
    r_s1 = 32'(rs1) << 15;
    r_s2 = 32'(rs2) << 20;
    e = '{inst: 0, pat: 0, err: 1'b0, has_lit: 1'b0, lit_inst: 0, lit_pat: 0, lit_err: 1'b0};
    case (op)
      3'd0: begin
        e.err  = (imm % 4096) != 0;
        e.inst = (imm & 32'hFFFF_F000) | r_d | 32'h17;
        e.pat  = 8'h05;
      end
      3'd1: begin
        e.err  = (simm % 2 != 0) || (simm < -1048576) || (simm > 1048574);
        e.inst = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
               | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | r_d | 32'h6F;
        e.pat  = 8'h1B;
      end
      3'd2, 3'd4: begin
        e.err  = (simm < -2048) || (simm > 2047);
        e.inst = ((imm & 32'hFFF) << 20) | r_s1 | r_d | ((op == 3'd2) ? 32'h67 : 32'h13);
        e.pat  = (op == 3'd2) ? 8'h19 : 8'h04;
      end
      3'd3: begin
        e.err  = (simm < -2048) || (simm > 2047);
        e.inst = (((imm >> 5) & 32'h7F) << 25) | r_s2 | r_s1 | (32'd2 << 12)
               | ((imm & 32'h1F) << 7) | 32'h23;
        e.pat  = 8'h48;
      end
      3'd5: begin
        e.inst = 32'h0010_0073;
        e.pat  = 8'h1C;
      end
      default: e.err = 1'b1;
    endcase
    if (e.err) begin
      e.inst = 32'h0000_0013;
      e.pat  = 8'h04;
    end
    return e;
  endfunction

  // Monitor: state checks reflect the last edge, model updates predict the next one.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      sb_q.delete();
      model_cnt    = 0;
      model_sticky = 1'b0;
      mon_en       = 1'b1;
    end else if (mon_en) begin
      check("enc_count", bus.enc_count, model_cnt);
      check("err_sticky", 32'(bus.err_sticky), 32'(model_sticky));
      check("out_valid", 32'(bus.out_valid), 32'(sb_q.size() != 0));
      check("in_ready", 32'(bus.in_ready), 32'(sb_q.size() < DEPTH));
      if (bus.out_valid && bus.out_ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("out_inst", bus.out_inst, e.inst);
        check("out_pattern", 32'(bus.out_pattern), 32'(e.pat));
        check("out_err", 32'(bus.out_err), 32'(e.err));
        if (e.has_lit) begin
          check("lit_inst", bus.out_inst, e.lit_inst);
          check("lit_pattern", 32'(bus.out_pattern), 32'(e.lit_pat));
          check("lit_err", 32'(bus.out_err), 32'(e.lit_err));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
        e.has_lit  = lit_has;
        e.lit_inst = lit_inst;
        e.lit_pat  = lit_pat;
        e.lit_err  = lit_err;
        sb_q.push_back(e);
        model_cnt++;
        model_sticky = model_sticky | e.err;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drive(logic [2:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                       logic [31:0] imm, bit has, logic [31:0] li, logic [7:0] lp, logic le);
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    lit_has      = has;
    lit_inst     = li;
    lit_pat      = lp;
    lit_err      = le;
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lit_has      = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL accept_timeout: got in_ready=%0b expected 1 within 200 cycles", bus.in_ready);
    bus.in_valid = 1'b0;
    lit_has      = 1'b0;
  endtask

  task automatic send_lit(logic [2:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                          logic [31:0] imm, logic [31:0] li, logic [7:0] lp, logic le);
    drive(op, rd, rs1, rs2, imm, 1'b1, li, lp, le);
    wait_accept();
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && bus.out_valid === 1'b0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout: got %0d queued expected 0", sb_q.size());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] imm;
    logic [31:0] bnd [10];
    bnd = '{32'hFFFF_F800, 32'h0000_07FF, 32'h0000_0800, 32'hFFFF_F7FF, 32'hFFF0_0000,
            32'h000F_FFFE, 32'h0010_0000, 32'hFFEF_FFFE, 32'h7FFF_F000, 32'h8000_0000};
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_inst", bus.out_inst, 32'h0);
    check("rst_out_pattern", 32'(bus.out_pattern), 32'h0);
    check("rst_out_err", 32'(bus.out_err), 32'h0);
    @(posedge clk);
    #1;

    // Basic encodings, one-cycle latency from accept to out_valid
    send_lit(3'd4, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 8'h04, 1'b0);
    @(negedge clk);
    check("t1_latency_valid", 32'(bus.out_valid), 32'h1);
    check("t1_enc_count", bus.enc_count, 32'd1);
    @(posedge clk);
    #1;
    send_lit(3'd1, 5'd1, 5'd0, 5'd0, 32'd8, 32'h0080_00EF, 8'h1B, 1'b0);
    send_lit(3'd3, 5'd0, 5'd3, 5'd2, 32'hFFFF_FFFC, 32'hFE21_AE23, 8'h48, 1'b0);
    send_lit(3'd0, 5'd2, 5'd0, 5'd0, 32'h0000_1000, 32'h0000_1117, 8'h05, 1'b0);
    drain();
    check("t2_sticky_clear", 32'(bus.err_sticky), 32'h0);

    // Error requests collapse to NOP
    send_lit(3'd0, 5'd2, 5'd0, 5'd0, 32'h0000_1004, 32'h0000_0013, 8'h04, 1'b1);
    send_lit(3'd1, 5'd1, 5'd0, 5'd0, 32'd7, 32'h0000_0013, 8'h04, 1'b1);
    send_lit(3'd4, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0000_0013, 8'h04, 1'b1);
    send_lit(3'd6, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0000_0013, 8'h04, 1'b1);
    drain();
    check("t3_sticky_set", 32'(bus.err_sticky), 32'h1);

    // EBREAK ignores operand fields
    for (int i = 0; i < 3; i++)
      send_lit(3'd5, 5'($urandom), 5'($urandom), 5'($urandom), $urandom,
               32'h0010_0073, 8'h1C, 1'b0);
    drain();

    // Backpressure: third request held until the consumer drains
    do_reset();
    bus.out_ready = 1'b0;
    send_lit(3'd4, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 8'h04, 1'b0);
    send_lit(3'd4, 5'd1, 5'd0, 5'd0, 32'd2, 32'h0020_0093, 8'h04, 1'b0);
    drive(3'd4, 5'd1, 5'd0, 5'd0, 32'd3, 1'b1, 32'h0030_0093, 8'h04, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("t5_full_in_ready", 32'(bus.in_ready), 32'h0);
      check("t5_held_count", bus.enc_count, 32'd2);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_accept();
    drain();
    check("t5_final_count", bus.enc_count, 32'd3);

    // Reset discards queued entries
    bus.out_ready = 1'b0;
    send_lit(3'd7, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000_0013, 8'h04, 1'b1);
    send_lit(3'd4, 5'd1, 5'd0, 5'd0, 32'd9, 32'h0090_0093, 8'h04, 1'b0);
    @(negedge clk);
    check("t6_pre_sticky", 32'(bus.err_sticky), 32'h1);
    check("t6_pre_valid", 32'(bus.out_valid), 32'h1);
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("t6_valid", 32'(bus.out_valid), 32'h0);
    check("t6_in_ready", 32'(bus.in_ready), 32'h1);
    check("t6_count", bus.enc_count, 32'h0);
    check("t6_sticky", 32'(bus.err_sticky), 32'h0);
    @(posedge clk);
    #1;

    // Randomized traffic with random consumer stalls
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      case ($urandom_range(0, 4))
        0: imm = 32'($urandom_range(0, 127)) - 32'd64;
        1: imm = $urandom;
        2: imm = bnd[$urandom_range(0, 9)];
        3: imm = $urandom & 32'hFFFF_F000;
        default: imm = ($urandom & 32'h001F_FFFE) - 32'h0010_0000;
      endcase
      drive(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom), imm,
            1'b0, 32'h0, 8'h0, 1'b0);
      wait_accept();
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
